// File: rtl/stream_dword_serializer_if.sv
// Handshake bundle for stream_dword_serializer: dword write side and byte-beat read side.
// master drives words in and provides out_ready; slave is the serializer.
interface stream_dword_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, in_bytes, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_bytes, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_dword_serializer.sv
// Word FIFO feeding a word register that emits each dword little-endian as 8-bit beats.
// The next word is popped on the last beat's handshake so consecutive words have no bubble.
module stream_dword_serializer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    stream_dword_serializer_if.slave bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [COUNT_WIDTH-1:0]   byte_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [COUNT_WIDTH-1:0] CountOne = 1;

    typedef enum logic {StEmpty, StActive} state_e;

    logic [33:0]            r_mem [DEPTH];
    logic [AW:0]            r_wptr;
    logic [AW:0]            r_rptr;
    state_e                 r_state;
    logic [31:0]            r_word;
    logic [1:0]             r_bytes;
    logic [1:0]             r_idx;
    logic [COUNT_WIDTH-1:0] r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_beat;
    logic        w_last;
    logic        w_pop;
    logic        w_active;
    logic [33:0] w_head;

    // Full/empty come from registered pointers only, so in_ready never sees out_ready.
    assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_active = (r_state == StActive);
    assign w_last   = (r_idx == r_bytes);
    assign w_push   = bus.in_valid && !w_full && !flush;
    assign w_beat   = w_active && bus.out_ready && !flush;
    assign w_pop    = !flush && !w_empty && (!w_active || (w_beat && w_last));
    assign w_head   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {bus.in_bytes, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_state <= StEmpty;
            r_word  <= '0;
            r_bytes <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_state <= StEmpty;
            r_word  <= '0;
            r_bytes <= '0;
            r_idx   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrOne;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrOne;
            end
            if (w_beat) begin
                r_count <= r_count + CountOne;
            end
            if (w_pop) begin
                r_word  <= w_head[31:0];
                r_bytes <= w_head[33:32];
                r_idx   <= 2'd0;
                r_state <= StActive;
            end else if (w_beat) begin
                if (w_last) begin
                    r_state <= StEmpty;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    always_comb begin
        bus.out_data = 8'h00;
        if (w_active) begin
            unique case (r_idx)
                2'd0: bus.out_data = r_word[7:0];
                2'd1: bus.out_data = r_word[15:8];
                2'd2: bus.out_data = r_word[23:16];
                2'd3: bus.out_data = r_word[31:24];
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = w_active;
    assign bus.out_last  = w_active && w_last;
    assign fifo_level    = r_wptr - r_rptr;
    assign byte_count    = r_count;
endmodule

// File: tb/tb_stream_dword_serializer.sv
// Directed bench for stream_dword_serializer: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every accepted output beat.
module tb_stream_dword_serializer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [2:0]  fifo_level;
    logic [15:0] byte_count;

    stream_dword_serializer_if bus ();

    stream_dword_serializer #(
        .DEPTH       (4),
        .COUNT_WIDTH (16)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .bus        (bus),
        .fifo_level (fifo_level),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_e;
    logic [15:0] base;
    logic [15:0] snap;
    logic        v;
    logic        l;
    logic [7:0]  d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Accepted beat = valid && ready at the edge, sampled half a cycle earlier.
    always @(negedge clk) begin
        if (reset_n && !flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got 0x%0h, want no beat", bus.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", {24'h0, bus.out_data}, {24'h0, mon_e[7:0]});
                chk("beat_last", {31'h0, bus.out_last}, {31'h0, mon_e[8]});
            end
        end
    end

    task automatic push(input logic [31:0] wd, input logic [1:0] wb);
        logic ok;
        int   n;
        for (int i = 0; i <= int'(wb); i++) begin
            exp_q.push_back({(i == int'(wb)), wd[i*8 +: 8]});
        end
        bus.in_valid = 1'b1;
        bus.in_data  = wd;
        bus.in_bytes = wb;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got no accept, want accept of 0x%0h", wd);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        reset_n      = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_bytes = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'h0, bus.in_ready}, 1);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 0);
        chk("rst_out_data", {24'h0, bus.out_data}, 0);
        chk("rst_out_last", {31'h0, bus.out_last}, 0);
        chk("rst_fifo_level", {29'h0, fifo_level}, 0);
        chk("rst_byte_count", {16'h0, byte_count}, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single 4-byte word, one-cycle pop latency.
        bus.out_ready = 1'b1;
        base = byte_count;
        push(32'h44332211, 2'd3);
        chk("t1_valid_at_write", {31'h0, bus.out_valid}, 0);
        @(posedge clk);
        #1;
        chk("t1_valid_after_pop", {31'h0, bus.out_valid}, 1);
        chk("t1_first_data", {24'h0, bus.out_data}, 32'h11);
        drain();
        chk("t1_byte_count", {16'h0, 16'(byte_count - base)}, 4);

        // Back-to-back short words, no bubble between them.
        base = byte_count;
        push(32'hAABBCCDD, 2'd1);
        push(32'h000000EE, 2'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_no_bubble", {31'h0, bus.out_valid}, 1);
            @(posedge clk);
            #1;
        end
        drain();
        chk("t2_byte_count", {16'h0, 16'(byte_count - base)}, 3);

        // Backpressure: fill FIFO behind a stalled word register.
        bus.out_ready = 1'b0;
        base = byte_count;
        for (int i = 0; i < 5; i++) begin
            push(32'h13121110 + 32'(i) * 32'h04040404, 2'd3);
        end
        chk("t3_level_full", {29'h0, fifo_level}, 4);
        chk("t3_in_ready_low", {31'h0, bus.in_ready}, 0);
        chk("t3_out_valid", {31'h0, bus.out_valid}, 1);
        chk("t3_out_data", {24'h0, bus.out_data}, 32'h10);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_stable_data", {24'h0, bus.out_data}, 32'h10);
        chk("t3_stable_last", {31'h0, bus.out_last}, 0);
        chk("t3_stable_level", {29'h0, fifo_level}, 4);
        bus.out_ready = 1'b1;
        drain();
        chk("t3_byte_count", {16'h0, 16'(byte_count - base)}, 20);
        chk("t3_level_empty", {29'h0, fifo_level}, 0);

        // Alternating out_ready: outputs hold during low cycles.
        bus.out_ready = 1'b0;
        push(32'h87654321, 2'd3);
        push(32'h0000A5C3, 2'd1);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            bus.out_ready = 1'b0;
            v = bus.out_valid;
            d = bus.out_data;
            l = bus.out_last;
            @(posedge clk);
            #1;
            if (v) begin
                chk("t4_hold_valid", {31'h0, bus.out_valid}, 1);
                chk("t4_hold_data", {24'h0, bus.out_data}, {24'h0, d});
                chk("t4_hold_last", {31'h0, bus.out_last}, {31'h0, l});
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        drain();

        // Flush mid-word with two words queued.
        bus.out_ready = 1'b0;
        push(32'h31302F2E, 2'd3);
        push(32'h41404F4E, 2'd3);
        push(32'h51505F5E, 2'd3);
        chk("t5_level_queued", {29'h0, fifo_level}, 2);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        snap = byte_count;
        exp_q.delete();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("t5_valid_cleared", {31'h0, bus.out_valid}, 0);
        chk("t5_level_cleared", {29'h0, fifo_level}, 0);
        chk("t5_in_ready", {31'h0, bus.in_ready}, 1);
        chk("t5_count_kept", {16'h0, byte_count}, {16'h0, snap});
        base = byte_count;
        push(32'h00776655, 2'd2);
        drain();
        chk("t5_after_flush", {16'h0, 16'(byte_count - base)}, 3);

        // Asynchronous reset during the third byte.
        push(32'hDEADBEEF, 2'd3);
        repeat (3) @(posedge clk);
        #3;
        chk("t6_third_byte", {24'h0, bus.out_data}, 32'hAD);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_out_valid", {31'h0, bus.out_valid}, 0);
        chk("t6_rst_out_data", {24'h0, bus.out_data}, 0);
        chk("t6_rst_out_last", {31'h0, bus.out_last}, 0);
        chk("t6_rst_byte_count", {16'h0, byte_count}, 0);
        chk("t6_rst_level", {29'h0, fifo_level}, 0);
        chk("t6_rst_in_ready", {31'h0, bus.in_ready}, 1);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(32'h0000FFEE, 2'd1);
        drain();
        chk("t6_byte_count", {16'h0, byte_count}, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
